cdb_arbiter: RTL

- Shares the single register-file commit port (register_update_flag / register_commit_dest / register_commit_value / rename_of_commit_ins) between NUM_REQ result producers: ALU, load/store buffer, branch unit, spare.
- Each producer gets a one-entry holding slot. One slot per cycle is picked round-robin and broadcast on a registered CDB.
- Also honours the global stall (rdy) and the predictor flush (register_flush).

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter_rr_picker.sv | 47 ++++
 rtl/cdb_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared widths, CDB entry type and the x0 value-zeroing helper for the CDB arbiter.
package cdb_pkg;
    localparam int REG_W  = 5;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] value;
        logic [TAG_W-1:0]  rename;
    } cdb_entry_t;

    // x0 still broadcasts so its rename tag is freed, but never carries a value.
    function automatic cdb_entry_t x0_force(input cdb_entry_t e);
        cdb_entry_t r;
        r = e;
        if (e.dest == '0) r.value = '0;
        return r;
    endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side request bus and the registered commit (CDB) bus of the arbiter.
interface cdb_arbiter_if #(parameter int NUM_REQ = 4);
    import cdb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*REG_W-1:0]  req_dest;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ*TAG_W-1:0]  req_rename;

    logic                      register_update_flag;
    logic [REG_W-1:0]          register_commit_dest;
    logic [DATA_W-1:0]         register_commit_value;
    logic [TAG_W-1:0]          rename_of_commit_ins;
    logic [2:0]                grant_id;

    modport master (
        output req_valid, req_dest, req_value, req_rename,
        input  req_ready, register_update_flag, register_commit_dest,
               register_commit_value, rename_of_commit_ins, grant_id
    );

    modport slave (
        input  req_valid, req_dest, req_value, req_rename,
        output req_ready, register_update_flag, register_commit_dest,
               register_commit_value, rename_of_commit_ins, grant_id
    );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin one-hot picker starting at rr_ptr; CDB_ARB_FIXED_PRIORITY_EN selects lowest-index-wins instead.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               any_grant
);
    logic       hit_hi;
    logic [2:0] idx_hi;
    logic [2:0] idx_lo;

    // Descending scan so the lowest index wins in both searches: idx_lo over
    // all requests, idx_hi over requests at or above the pointer (pre-wrap).
    always_comb begin
        hit_hi    = 1'b0;
        idx_hi    = '0;
        idx_lo    = '0;
        any_grant = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                any_grant = 1'b1;
                idx_lo    = 3'(k);
            end
            if (req[k] && (3'(k) >= rr_ptr)) begin
                hit_hi = 1'b1;
                idx_hi = 3'(k);
            end
        end
    end

`ifdef CDB_ARB_FIXED_PRIORITY_EN
    logic unused_rr;
    assign unused_rr = hit_hi ^ (^idx_hi);
    assign idx       = idx_lo;
`else
    assign idx = hit_hi ? idx_hi : idx_lo;
`endif

    always_comb begin
        grant = '0;
        for (int k = 0; k < NUM_REQ; k++)
            grant[k] = any_grant && (idx == 3'(k));
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates NUM_REQ result producers onto the single registered commit bus via one-entry slots.
// Build option: CDB_ARB_FIXED_PRIORITY_EN replaces round-robin with fixed lowest-index priority.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             register_flush,
    cdb_arbiter_if.slave     bus
);
    logic [NUM_REQ-1:0] slot_valid;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    cdb_entry_t         slot  [NUM_REQ];
    cdb_entry_t         req_e [NUM_REQ];
    cdb_entry_t         sel;
    cdb_entry_t         bcast;
    logic [2:0]         rr_ptr;
    logic [2:0]         gnt_idx;
    logic               any_grant;
    logic               advance;

    assign advance = rdy && !register_flush;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (slot_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .idx       (gnt_idx),
        .any_grant (any_grant)
    );

    // Ready comes from slot state only, so there is no valid->ready path.
    assign bus.req_ready = {NUM_REQ{advance}} & (~slot_valid | grant);
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_e[i].dest   = bus.req_dest[i*REG_W +: REG_W];
            req_e[i].value  = bus.req_value[i*DATA_W +: DATA_W];
            req_e[i].rename = bus.req_rename[i*TAG_W +: TAG_W];
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) sel = slot[i];
    end

    assign bcast = x0_force(sel);

    // Capture beats clear when a granted slot is refilled on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid <= '0;
            for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
        end else if (rdy && register_flush) begin
            slot_valid <= '0;
        end else if (rdy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot[i]       <= req_e[i];
                end else if (grant[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.register_update_flag  <= 1'b0;
            bus.register_commit_dest  <= '0;
            bus.register_commit_value <= '0;
            bus.rename_of_commit_ins  <= '0;
            bus.grant_id              <= '0;
        end else if (rdy) begin
            if (register_flush) begin
                bus.register_update_flag <= 1'b0;
            end else if (any_grant) begin
                bus.register_update_flag  <= 1'b1;
                bus.register_commit_dest  <= bcast.dest;
                bus.register_commit_value <= bcast.value;
                bus.rename_of_commit_ins  <= bcast.rename;
                bus.grant_id              <= gnt_idx;
            end else begin
                bus.register_update_flag <= 1'b0;
            end
        end
    end

`ifdef CDB_ARB_FIXED_PRIORITY_EN
    assign rr_ptr = 3'd0;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_ptr <= 3'd0;
        else if (advance && any_grant)
            rr_ptr <= (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
`endif
endmodule
